sram_bus_sequencer: RTL



---
 rtl/sram_bus_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/sram_bus_sequencer.sv
// Sequences single-byte 65C816 bus requests onto sram_ctrl5 as setup/strobe/hold cycles.
// Optional write protection of offsets >= WP_BASE is enabled by defining SRAM_SEQ_WP_EN.
module sram_bus_sequencer #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [7:0]  RAM_BANK    = 8'h00,
    parameter logic [15:0] WP_BASE     = 16'hE000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        rw,
    input  logic [23:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ack,
    output logic        err,
    output logic        busy,
    output logic        ram_e,
    output logic        wr_n,
    output logic        rd_n,
    output logic [15:0] sram_addr,
    output logic [7:0]  sram_wdata,
    input  logic [7:0]  sram_rdata
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
`ifdef SRAM_SEQ_WP_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    state_t     state, state_nx;
    logic [3:0] cnt;
    logic       rw_q;
    logic       err_pend;
    logic       miss_dly, miss_dly_nx;
    logic       accept, bank_hit, wp_hit, go_sram;

    always_comb begin
        accept   = (state == IDLE) && req;
        bank_hit = (addr[23:16] == RAM_BANK);
        wp_hit   = WP_EN && !rw && (addr[15:0] >= WP_BASE);
        go_sram  = bank_hit && !wp_hit;
    end

    // Error completions wait one extra cycle in DONE so ack lands two edges after accept.
    always_comb begin
        state_nx    = state;
        miss_dly_nx = miss_dly;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nx    = go_sram ? SETUP : DONE;
                    miss_dly_nx = !go_sram;
                end
            end
            SETUP:   state_nx = STROBE;
            STROBE:  if (cnt == 4'd0) state_nx = HOLD;
            HOLD:    state_nx = DONE;
            DONE: begin
                miss_dly_nx = 1'b0;
                if (!miss_dly) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            miss_dly   <= 1'b0;
            cnt        <= 4'd0;
            rw_q       <= 1'b1;
            err_pend   <= 1'b0;
            sram_addr  <= 16'h0000;
            sram_wdata <= 8'h00;
            rdata      <= 8'h00;
            ack        <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            ram_e      <= 1'b0;
            wr_n       <= 1'b1;
            rd_n       <= 1'b1;
        end else begin
            state    <= state_nx;
            miss_dly <= miss_dly_nx;
            if (accept) begin
                rw_q       <= rw;
                sram_addr  <= addr[15:0];
                sram_wdata <= wdata;
                err_pend   <= !go_sram;
                if (!go_sram && rw) rdata <= 8'hFF;
            end
            if (state == SETUP) begin
                cnt <= WAIT_LD;
            end else if ((state == STROBE) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if ((state == STROBE) && (cnt == 4'd0) && rw_q) rdata <= sram_rdata;
            // Strobes are registered from the next state so the SRAM pins never glitch.
            ram_e <= (state_nx == SETUP) || (state_nx == STROBE) || (state_nx == HOLD);
            rd_n  <= !((state_nx == STROBE) && rw_q);
            wr_n  <= !((state_nx == STROBE) && !rw_q);
            busy  <= (state_nx != IDLE);
            ack   <= (state_nx == DONE) && !miss_dly_nx;
            err   <= (state_nx == DONE) && !miss_dly_nx && err_pend;
        end
    end

endmodule
